seq_mult8: RTL and testbench

SEQ_MULT8 -- requirements
Module: seq_mult8

---
 rtl/seq_mult8_pkg.sv | 23 ++
 rtl/seq_mult8_if.sv | 36 +++
 rtl/seq_mult8_add8_cout.sv | 59 +++++
 rtl/seq_mult8.sv | 116 +++++++++++
 tb/tb_seq_mult8.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/seq_mult8_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
//   DEF_WIDTH   default operand width
//   state_t     FSM state encoding (IDLE / RUN / DONE)
//   cnt_width() iteration-counter width for a given operand width
package seq_mult8_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned ST_W      = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold 0..WIDTH, hence one bit above clog2.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_mult8_if.sv
// Request/response bundle of the multiplier.
//   start, a, b        : requester -> multiplier
//   busy, done, product: multiplier -> requester
// master = requester side, slave = multiplier side.
interface seq_mult8_if
    import seq_mult8_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );

endinterface

// File: rtl/seq_mult8_add8_cout.sv
// add8_cout: WIDTH-bit carry-lookahead adder with carry-out, purely combinational.
//   a, b  : addends
//   cin   : carry-in
//   sum   : WIDTH-bit sum
//   cout  : carry-out of the top bit
module add8_cout
    import seq_mult8_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;
    logic             chain;
    logic             term;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is a flat sum of products of generate/propagate terms,
    // so no carry depends on the one below it.
    always_comb begin
        c     = '0;
        chain = 1'b0;
        term  = 1'b0;
        c[0]  = cin;
        for (int i = 0; i < WIDTH; i++) begin
            chain = cin;
            for (int k = 0; k < WIDTH; k++) begin
                if (k <= i) begin
                    chain = chain & p[k];
                end
            end
            for (int j = 0; j < WIDTH; j++) begin
                if (j <= i) begin
                    term = g[j];
                    for (int k = 0; k < WIDTH; k++) begin
                        if ((k > j) && (k <= i)) begin
                            term = term & p[k];
                        end
                    end
                    chain = chain | term;
                end
            end
            c[i+1] = chain;
        end
    end

    assign sum  = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/seq_mult8.sv
// seq_mult8: unsigned sequential shift-add multiplier, one multiplier bit per cycle.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seq_mult8_if.slave -- start/a/b in, busy/done/product out
// A start accepted in IDLE or DONE latches the operands; RUN lasts WIDTH
// cycles; DONE is a single cycle in which done is high and product is new.
module seq_mult8
    import seq_mult8_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    seq_mult8_if.slave    bus
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    product_q;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last;
    logic             busy_c;
    logic             done_c;

    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_s;
    logic             add_co;

    // Start is only honoured outside RUN; a start during RUN is dropped.
    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (cnt == CW'(WIDTH - 1));

    // Add the multiplicand into the upper half when the current multiplier bit is set.
    assign add_b = acc[0] ? mcand : '0;

    add8_cout #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (acc[PW-1:WIDTH]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_s),
        .cout (add_co)
    );

    // {carry, sum, low half} shifted right by one; the carry lands in the MSB.
    assign acc_nxt = {add_co, add_s, acc[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the registered state
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        unique case (state)
            ST_RUN:  busy_c = 1'b1;
            ST_DONE: done_c = 1'b1;
            default: begin
                busy_c = 1'b0;
                done_c = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, shift-add iteration and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
            product_q <= '0;
        end else if (accept) begin
            mcand <= bus.a;
            acc   <= {{WIDTH{1'b0}}, bus.b};
            cnt   <= '0;
        end else if (state == ST_RUN) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                product_q <= acc_nxt;
            end
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_mult8.sv
// Scoreboard bench for seq_mult8: stimulus pushes expected product and
// expected done cycle; an independent monitor pops on every done pulse.
module tb_seq_mult8;

    typedef struct {
        logic [15:0] prod;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q[$];

    seq_mult8_if #(.WIDTH(8)) bus ();

    seq_mult8 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no done (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("product", 32'(bus.product), 32'(e.prod));
                check("latency", cyc, e.due);
                check("busy_in_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    // Wait for the multiplier to leave RUN, then present one start for one cycle.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] req);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy === 1'b1) check("issue_wait", 32'(bus.busy), 32'd0);
        bus.a     = ia;
        bus.b     = ib;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{prod: req, due: cyc + 8});
        bus.start = 1'b0;
        // Scramble operands after acceptance; the running op must ignore them.
        bus.a     = ~ia;
        bus.b     = ib ^ 8'h5a;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int nb;
        logic [7:0] ra;
        logic [7:0] rb;

        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_product", 32'(bus.product), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 13*11 and busy duration
        issue(8'd13, 8'd11, 16'h008F);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) nb++;
        end
        check("busy_cycles", 32'(nb), 32'd8);
        drain();

        // Corner operands
        issue(8'hFF, 8'hFF, 16'hFE01);
        issue(8'h00, 8'hFF, 16'h0000);
        issue(8'h80, 8'h02, 16'h0100);
        issue(8'h01, 8'h80, 16'h0080);
        drain();

        // Start during RUN is ignored
        issue(8'd4, 8'd12, 16'h0030);
        @(negedge clk);
        @(negedge clk);
        bus.a     = 8'd99;
        bus.b     = 8'd99;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // start held high: back-to-back every 9 cycles
        bus.a     = 8'd4;
        bus.b     = 8'd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{prod: 16'd8, due: cyc + 8});
        q.push_back('{prod: 16'd8, due: cyc + 17});
        q.push_back('{prod: 16'd8, due: cyc + 26});
        repeat (18) @(posedge clk);
        #1;
        bus.start = 1'b0;
        drain();

        // Random sweep against the reference product
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            issue(ra, rb, 16'(ra) * 16'(rb));
        end
        drain();

        // Asynchronous reset mid-RUN aborts the operation
        issue(8'd200, 8'd3, 16'd600);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_product", 32'(bus.product), 32'd0);
        q.delete();
        repeat (3) @(negedge clk);
        check("abort_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue(8'd7, 8'd9, 16'd63);
        drain();

        // Result holds after completion
        repeat (5) @(negedge clk);
        check("hold_product", 32'(bus.product), 32'd63);
        check("idle_busy", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
